// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: push-side and transmitter-side signals of the UART TX feeder.
// The master modport is the producer/transmitter side, the slave modport is the feeder.
interface uart_tx_feeder_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // producer push port
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;

  // FIFO status
  logic                 full;
  logic                 empty;
  logic [LVL_W-1:0]     level;
  logic                 overflow;

  // transmitter handshake
  logic                 tx_ready;
  logic                 tx_enable;
  logic [DATA_BITS-1:0] tx_data;

  modport master (
    output wr_en, wr_data, tx_ready,
    input  full, empty, level, overflow, tx_enable, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_ready,
    output full, empty, level, overflow, tx_enable, tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of the UART transmitter. Bytes are issued one at
// a time with a single-cycle tx_enable pulse; after each issue the controller waits for
// tx_ready to drop and rise again, so the transmitter's lagging ready never re-issues.
// Build macro UART_TX_FEEDER_HEX_EN: each byte is sent as two upper-case ASCII hex
// characters, high nibble first (requires DATA_BITS == 8).
module uart_tx_feeder #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk_in,
  input  logic            n_rst,
  uart_tx_feeder_if.slave bus
);
  localparam int               PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int               LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_BUSY  = 2'd1,
    ST_WAIT_READY = 2'd2
`ifdef UART_TX_FEEDER_HEX_EN
    ,
    ST_HEX_LO     = 2'd3
`endif
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;

  // issue controller
  state_t               state_q, state_d;
  logic                 tx_enable_q, tx_enable_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

`ifdef UART_TX_FEEDER_HEX_EN
  // popped byte kept for the low-nibble character, and a flag marking that it is owed
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 lo_pend_q, lo_pend_d;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction
`endif

  logic                 full_w;
  logic                 empty_w;
  logic                 push_w;
  logic                 pop_w;
  logic [DATA_BITS-1:0] head_w;

  // full is judged on the pre-edge level, so a pop on the same edge never frees room
  assign full_w  = (count_q == DEPTH_L);
  assign empty_w = (count_q == '0);
  assign push_w  = bus.wr_en && !full_w;
  assign head_w  = mem_q[rd_ptr_q];

  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.level     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.tx_enable = tx_enable_q;
  assign bus.tx_data   = tx_data_q;

  // write port of the buffer; contents need no reset since count gates every read
  always_ff @(posedge clk_in) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // pointer, occupancy and overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = bus.wr_en && full_w;
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_w && !pop_w) begin
      count_d = count_q + LVL_W'(1);
    end else if (!push_w && pop_w) begin
      count_d = count_q - LVL_W'(1);
    end
  end

  // issue FSM: decide next state, the pop and the registered issue outputs
  always_comb begin
    state_d     = state_q;
    tx_enable_d = 1'b0;
    tx_data_d   = tx_data_q;
    pop_w       = 1'b0;
`ifdef UART_TX_FEEDER_HEX_EN
    hold_d      = hold_q;
    lo_pend_d   = lo_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty_w && bus.tx_ready) begin
          pop_w       = 1'b1;
          tx_enable_d = 1'b1;
`ifdef UART_TX_FEEDER_HEX_EN
          tx_data_d   = hex_char(head_w[7:4]);
          hold_d      = head_w;
          lo_pend_d   = 1'b1;
`else
          tx_data_d   = head_w;
`endif
          state_d     = ST_WAIT_BUSY;
        end
      end
      // ready may still read high for a cycle after the transmitter accepted
      ST_WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          state_d = ST_WAIT_READY;
        end
      end
      ST_WAIT_READY: begin
        if (bus.tx_ready) begin
`ifdef UART_TX_FEEDER_HEX_EN
          state_d = lo_pend_q ? ST_HEX_LO : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef UART_TX_FEEDER_HEX_EN
      // second character of the pair: no pop, ready was just seen high
      ST_HEX_LO: begin
        tx_enable_d = 1'b1;
        tx_data_d   = hex_char(hold_q[3:0]);
        lo_pend_d   = 1'b0;
        state_d     = ST_WAIT_BUSY;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state registers, cleared asynchronously with the transmitter
  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= ST_IDLE;
      tx_enable_q <= 1'b0;
      tx_data_q   <= '0;
`ifdef UART_TX_FEEDER_HEX_EN
      hold_q      <= '0;
      lo_pend_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      tx_enable_q <= tx_enable_d;
      tx_data_q   <= tx_data_d;
`ifdef UART_TX_FEEDER_HEX_EN
      hold_q      <= hold_d;
      lo_pend_q   <= lo_pend_d;
`endif
    end
  end
endmodule
